// File: rtl/shift_add_mul_pkg.sv
// shift_add_mul_pkg: shared state encoding and counter sizing for the shift-and-add multiplier
package shift_add_mul_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/shift_add_mul_adder.sv
// adder: N-bit ripple adder with carry in/out, the one shared datapath element of the multiplier
module adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);
  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};
endmodule

// File: rtl/shift_add_mul.sv
// shift_add_mul: sequential N-bit unsigned multiplier, one shift-and-add step per cycle
// Optional SHIFT_ADD_MUL_EARLY_EXIT_EN skips the iterations when either operand is zero.
module shift_add_mul
  import shift_add_mul_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] Y
);
  localparam int CW = cnt_w(N);
  state_t r_state, w_next;
  logic [N-1:0] r_acc, r_q, r_m, w_b, w_sum;
  logic [CW-1:0] r_cnt;
  logic [2*N-1:0] r_y;
  logic r_busy, r_done, w_cout, w_accept, w_zero;
  assign w_b = r_q[0] ? r_m : '0;
  adder #(.N(N)) u_adder (
    .A(r_acc),
    .B(w_b),
    .Cin(1'b0),
    .Sum(w_sum),
    .Cout(w_cout)
  );
  always_comb begin
    w_accept = start && (r_state != RUN);
`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
    w_zero = (A == '0) || (B == '0);
`else
    w_zero = 1'b0;
`endif
    w_next = w_accept ? (w_zero ? DONE : RUN)
           : (r_state == RUN) ? ((r_cnt == '0) ? DONE : RUN)
           : IDLE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == RUN);
      r_done  <= (w_next == DONE);
      if (w_accept) begin
        r_m   <= A;
        r_acc <= '0;
        r_q   <= B;
        r_cnt <= CW'(N - 1);
        if (w_zero) r_y <= '0;
      end else if (r_state == RUN) begin
        // the (N+1)-bit sum shifts right one place across {acc, q}
        r_acc <= {w_cout, w_sum[N-1:1]};
        r_q   <= {w_sum[0], r_q[N-1:1]};
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == '0) r_y <= {w_cout, w_sum, r_q[N-1:1]};
      end
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign Y    = r_y;
endmodule

// File: tb/tb_shift_add_mul.sv
// tb_shift_add_mul: randomized and directed checks of shift_add_mul (N=4) against an arithmetic model
module tb_shift_add_mul;
  localparam int N = 4;
`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b0, start = 1'b0;
  logic [N-1:0] A = '0, B = '0;
  logic busy, done;
  logic [2*N-1:0] Y;
  int n_pass = 0, n_total = 0;
  logic [2*N-1:0] exp_y = '0;

  shift_add_mul #(.N(N)) dut (
    .clock(clock), .reset(reset), .start(start),
    .A(A), .B(B), .busy(busy), .done(done), .Y(Y)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit scramble);
    int lat;
    int exp_lat;
    logic [2*N-1:0] prod;
    prod = (2*N)'(int'(a) * int'(b));
    exp_lat = (EARLY && (a == 0 || b == 0)) ? 0 : N;
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 3 * N) begin
      check("busy_run", busy, 1);
      check("y_hold", Y, exp_y);
      if (scramble) begin
        A = N'($urandom);
        B = N'($urandom);
        start = 1'($urandom);
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check("latency", lat, exp_lat);
    check("product", Y, prod);
    check("busy_done", busy, 0);
    exp_y = prod;
    tick();
    check("done_pulse", done, 0);
    check("y_after", Y, exp_y);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_y", Y, 0);
    #4 reset = 1'b0;
    tick();
    do_op(4'd7, 4'd6, 1'b0);
    check("y_2a", Y, 8'h2A);
    do_op(4'd15, 4'd15, 1'b0);
    check("y_e1", Y, 8'hE1);
    for (int i = 0; i < 256; i++) do_op(N'(i >> 4), N'(i), 1'b0);
    for (int i = 0; i < 20; i++) do_op(N'($urandom), N'($urandom), 1'b1);
    do_op(4'd0, 4'd9, 1'b0);
    check("zero_y", Y, 0);
    // start held high: next pair offered in the DONE cycle
    A = 4'd3; B = 4'd5; start = 1'b1;
    tick();
    n = 0;
    while (!done && n < 20) begin
      A = N'($urandom); B = N'($urandom);
      tick();
      n++;
    end
    check("b2b_lat1", n, N);
    check("b2b_y1", Y, 15);
    A = 4'd9; B = 4'd9;
    tick();
    n = 1;
    while (!done && n < 20) begin
      A = N'($urandom); B = N'($urandom);
      tick();
      n++;
    end
    check("b2b_space", n, N + 1);
    check("b2b_y2", Y, 81);
    start = 1'b0;
    exp_y = 8'd81;
    tick();
    check("b2b_end", done, 0);
    // asynchronous abort in the middle of an operation
    A = 4'd12; B = 4'd11; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_abort_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_y", Y, 0);
    #2 reset = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) n++;
    end
    check("abort_nodone", n, 0);
    exp_y = '0;
    do_op(4'd12, 4'd11, 1'b1);
    check("y_84", Y, 8'h84);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
